// File: rtl/vga_pkg.sv
// Video mode descriptors shared by the timing generator and downstream draw stages.
// The H_*/V_* constants keep their historical 800x600 meaning.
package vga_pkg;

   typedef struct packed {
      logic [15:0] h_act;
      logic [15:0] h_sync_s;
      logic [15:0] h_sync_e;
      logic [15:0] h_tot;
      logic [15:0] v_act;
      logic [15:0] v_sync_s;
      logic [15:0] v_sync_e;
      logic [15:0] v_tot;
   } vga_mode_t;

   localparam int H_ACT        = 800;
   localparam int H_SYNC_START = 840;
   localparam int H_SYNC_END   = 968;
   localparam int H_TOT        = 1056;
   localparam int V_ACT        = 600;
   localparam int V_SYNC_START = 601;
   localparam int V_SYNC_END   = 605;
   localparam int V_TOT        = 628;

   localparam vga_mode_t VGA_MODE_800X600 = '{
      h_act: 16'(H_ACT), h_sync_s: 16'(H_SYNC_START), h_sync_e: 16'(H_SYNC_END), h_tot: 16'(H_TOT),
      v_act: 16'(V_ACT), v_sync_s: 16'(V_SYNC_START), v_sync_e: 16'(V_SYNC_END), v_tot: 16'(V_TOT)
   };

   localparam vga_mode_t VGA_MODE_640X480 = '{
      h_act: 16'd640, h_sync_s: 16'd656, h_sync_e: 16'd752, h_tot: 16'd800,
      v_act: 16'd480, v_sync_s: 16'd490, v_sync_e: 16'd492, v_tot: 16'd525
   };

endpackage

// File: rtl/vga_timing_axis.sv
// One timing axis: wrapping position counter with blanking/sync decoded from the
// next count, so the registered flags always line up with the registered count.
module vga_timing_axis #(
   parameter int CNT_W = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             adv,
   input  logic [CNT_W-1:0] act,
   input  logic [CNT_W-1:0] sync_s,
   input  logic [CNT_W-1:0] sync_e,
   input  logic [CNT_W-1:0] tot,
   input  logic             pol,
   output logic [CNT_W-1:0] count,
   output logic             blnk,
   output logic             sync,
   output logic             wrap
);

   logic [CNT_W-1:0] count_next;
   logic             sync_on;

   always_comb begin
      wrap       = adv && (count == tot - 1'b1);
      count_next = count;
      if (wrap)
         count_next = '0;
      else if (adv)
         count_next = count + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count   <= '0;
         blnk    <= 1'b0;
         sync_on <= 1'b0;
      end else begin
         count   <= count_next;
         blnk    <= (count_next >= act);
         sync_on <= (count_next >= sync_s) && (count_next < sync_e);
      end
   end

   // Polarity is a build-time constant, so this folds into the register output.
   assign sync = sync_on ? pol : ~pol;

endmodule

// File: rtl/vga_timing_multi.sv
// Two-mode VGA timing generator: H/V axes, frame-boundary mode switch, frame counter
// and sof/eol strobes (strobes are qualified by pix_en so they never fire on a hold cycle).
module vga_timing_multi
   import vga_pkg::*;
#(
   parameter int        CNT_W     = 11,
   parameter int        FRAME_W   = 8,
   parameter logic      HSYNC_POL = 1'b1,
   parameter logic      VSYNC_POL = 1'b1,
   parameter vga_mode_t MODE0     = VGA_MODE_800X600,
   parameter vga_mode_t MODE1     = VGA_MODE_640X480
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pix_en,
   input  logic               mode_sel,
   output logic [CNT_W-1:0]   hcount,
   output logic [CNT_W-1:0]   vcount,
   output logic               hblnk,
   output logic               vblnk,
   output logic               hsync,
   output logic               vsync,
   output logic               sof,
   output logic               eol,
   output logic [FRAME_W-1:0] frame_cnt,
   output logic               mode_active
);

   vga_mode_t cur;
   logic      h_wrap;
   logic      v_wrap;
   logic      sof_pend;

   assign cur = mode_active ? MODE1 : MODE0;

   vga_timing_axis #(.CNT_W(CNT_W)) u_h (
      .clk    (clk),
      .rst    (rst),
      .adv    (pix_en),
      .act    (CNT_W'(cur.h_act)),
      .sync_s (CNT_W'(cur.h_sync_s)),
      .sync_e (CNT_W'(cur.h_sync_e)),
      .tot    (CNT_W'(cur.h_tot)),
      .pol    (HSYNC_POL),
      .count  (hcount),
      .blnk   (hblnk),
      .sync   (hsync),
      .wrap   (h_wrap)
   );

   vga_timing_axis #(.CNT_W(CNT_W)) u_v (
      .clk    (clk),
      .rst    (rst),
      .adv    (h_wrap),
      .act    (CNT_W'(cur.v_act)),
      .sync_s (CNT_W'(cur.v_sync_s)),
      .sync_e (CNT_W'(cur.v_sync_e)),
      .tot    (CNT_W'(cur.v_tot)),
      .pol    (VSYNC_POL),
      .count  (vcount),
      .blnk   (vblnk),
      .sync   (vsync),
      .wrap   (v_wrap)
   );

   // v_wrap already implies the last pixel of the last line: this is the frame wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_active <= 1'b0;
         frame_cnt   <= '0;
         sof_pend    <= 1'b0;
      end else if (v_wrap) begin
         mode_active <= mode_sel;
         frame_cnt   <= frame_cnt + 1'b1;
         sof_pend    <= 1'b1;
      end else if (pix_en) begin
         sof_pend    <= 1'b0;
      end
   end

   assign eol = h_wrap;
   assign sof = sof_pend & pix_en;

endmodule
